// File: rtl/hack_pc_sequencer.sv
// HACK CPU fetch/branch sequencer: owns the PC, fetches over req/ack, holds the
// instruction for execute, and picks the next PC. Optional: HACK_PC_SELF_LOOP_HALT_EN.
module hack_pc_sequencer #(
  parameter int            PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic            instr_valid,
  output logic [15:0]     instr,
  input  logic            instr_ready,
  input  logic [PC_W-1:0] a_reg,
  input  logic            zr,
  input  logic            ng,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t          state, state_nxt;
  logic            boundary;
  logic            jump_take;
  logic            self_loop;
  logic [PC_W-1:0] pc_nxt;

  // Branch decision uses only the held instruction and the flags of this cycle.
  always_comb begin
    boundary  = (state == HOLD) && instr_ready;
    jump_take = instr[15] & ((instr[2] & ng) | (instr[1] & zr) | (instr[0] & ~ng & ~zr));
    pc_nxt    = jump_take ? a_reg : pc + PC_W'(1);
`ifdef HACK_PC_SELF_LOOP_HALT_EN
    self_loop = jump_take && (a_reg == pc);
`else
    self_loop = 1'b0;
`endif
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block and wins
  // over every other update, including an ack arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (run)      state_nxt = FETCH;
      FETCH: if (imem_ack) state_nxt = HOLD;
      HOLD:  if (instr_ready) state_nxt = (halt_req || self_loop) ? HALT : FETCH;
      HALT:  state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= '0;
    end else begin
      if (state == FETCH && imem_ack) instr <= imem_data;
      if (boundary)                   pc    <= pc_nxt;
    end
  end

  always_comb begin
    imem_req    = (state == FETCH);
    instr_valid = (state == HOLD);
    halted      = (state == HALT);
    imem_addr   = pc;
  end

endmodule

// File: tb/tb_hack_pc_sequencer.sv
// Directed bench for hack_pc_sequencer; a second instance with RESET_PC=16'hFFFF
// shares all stimulus and covers the PC wrap. Honors HACK_PC_SELF_LOOP_HALT_EN.
module tb_hack_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_ack, instr_ready, zr, ng, halt_req;
  logic [15:0] imem_data, a_reg;
  logic        imem_req, instr_valid, halted;
  logic [15:0] imem_addr, instr, pc;
  logic        imem_req2, instr_valid2, halted2;
  logic [15:0] imem_addr2, instr2, pc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hack_pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .a_reg(a_reg), .zr(zr), .ng(ng), .halt_req(halt_req), .pc(pc), .halted(halted)
  );

  hack_pc_sequencer #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid2), .instr(instr2), .instr_ready(instr_ready),
    .a_reg(a_reg), .zr(zr), .ng(ng), .halt_req(halt_req), .pc(pc2), .halted(halted2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes FETCH: ack immediately, then complete with the given A/flags.
  task automatic do_instr(input logic [15:0] word, input logic [15:0] a,
                          input logic z, input logic n);
    imem_ack = 1'b1; imem_data = word;
    tick();
    imem_ack = 1'b0;
    a_reg = a; zr = z; ng = n; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = 16'h0;
    instr_ready = 1'b0; zr = 1'b0; ng = 1'b0; halt_req = 1'b0; a_reg = 16'h0;
    tick(); tick();

    check("rst_req",    {15'b0, imem_req},    16'h0);
    check("rst_valid",  {15'b0, instr_valid}, 16'h0);
    check("rst_halted", {15'b0, halted},      16'h0);
    check("rst_pc",     pc,                   16'h0000);
    check("rst_instr",  instr,                16'h0000);
    check("rst_pc_wrap", pc2,                 16'hFFFF);

    rst_n = 1'b1;
    tick();
    check("idle_no_run", {15'b0, imem_req}, 16'h0);
    run = 1'b1;
    tick();

    // Sequential fetch of A-instructions, one-cycle ack and ready.
    for (int k = 0; k < 4; k++) begin
      check("inc_req",  {15'b0, imem_req}, 16'h1);
      check("inc_addr", imem_addr, 16'(k));
      imem_ack = 1'b1; imem_data = 16'h0005;
      tick();
      imem_ack = 1'b0;
      check("inc_valid", {15'b0, instr_valid}, 16'h1);
      check("inc_instr", instr, 16'h0005);
      check("inc_hold_req", {15'b0, imem_req}, 16'h0);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      check("inc_valid_drop", {15'b0, instr_valid}, 16'h0);
      check("inc_pc", pc, 16'(k + 1));
      if (k == 0) check("wrap_addr", imem_addr2, 16'h0000);
    end

    // Wait states: three idle ack cycles, then two idle ready cycles.
    for (int w = 0; w < 3; w++) begin
      tick();
      check("ws_req",  {15'b0, imem_req}, 16'h1);
      check("ws_addr", imem_addr, 16'h0004);
    end
    imem_ack = 1'b1; imem_data = 16'h0007;
    tick();
    imem_ack = 1'b0;
    for (int w = 0; w < 2; w++) begin
      check("ws_instr", instr, 16'h0007);
      check("ws_valid", {15'b0, instr_valid}, 16'h1);
      check("ws_pc",    pc, 16'h0004);
      tick();
    end
    // A-instruction with all low bits set and both flags high never jumps.
    a_reg = 16'h0100; zr = 1'b1; ng = 1'b1; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("ws_pc_adv", pc, 16'h0005);

    do_instr(16'hE307, 16'h0100, 1'b0, 1'b0); check("jmp",       pc, 16'h0100);
    do_instr(16'hE302, 16'h0200, 1'b0, 1'b0); check("jeq_nt",    pc, 16'h0101);
    do_instr(16'hE302, 16'h0200, 1'b1, 1'b0); check("jeq_t",     pc, 16'h0200);
    do_instr(16'hE301, 16'h0300, 1'b0, 1'b1); check("jgt_nt",    pc, 16'h0201);
    do_instr(16'hE301, 16'h0300, 1'b0, 1'b0); check("jgt_t",     pc, 16'h0300);
    do_instr(16'h0007, 16'h0400, 1'b1, 1'b1); check("ainstr_nj", pc, 16'h0301);

    // halt_req raised mid-fetch: the fetch completes, HALT at the boundary.
    halt_req = 1'b1;
    tick();
    check("halt_fetch_req", {15'b0, imem_req}, 16'h1);
    imem_ack = 1'b1; imem_data = 16'h0005;
    tick();
    imem_ack = 1'b0;
    check("halt_hold_valid", {15'b0, instr_valid}, 16'h1);
    check("halt_not_yet",    {15'b0, halted},      16'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0; halt_req = 1'b0;
    check("halted",      {15'b0, halted},      16'h1);
    check("halt_pc",     pc,                   16'h0302);
    check("halt_req_lo", {15'b0, imem_req},    16'h0);
    tick(); tick();
    check("halt_stay",   {15'b0, halted},      16'h1);
    check("halt_pc_frz", pc,                   16'h0302);

    // Self-loop jump at 16'h0010.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_instr(16'hE307, 16'h0010, 1'b0, 1'b0);
    check("sl_pc", pc, 16'h0010);
    do_instr(16'hEA87, 16'h0010, 1'b0, 1'b0);
`ifdef HACK_PC_SELF_LOOP_HALT_EN
    check("sl_halted", {15'b0, halted},   16'h1);
    check("sl_no_req", {15'b0, imem_req}, 16'h0);
    tick();
    check("sl_no_req2", {15'b0, imem_req}, 16'h0);
`else
    check("sl_halted", {15'b0, halted},   16'h0);
    check("sl_req",    {15'b0, imem_req}, 16'h1);
    check("sl_addr",   imem_addr,         16'h0010);
`endif
    check("sl_pc_keep", pc, 16'h0010);

    // Reset while a fetch is outstanding, with an ack in the same cycle.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_instr(16'h0005, 16'h0000, 1'b0, 1'b0);
    check("mid_pre_req", {15'b0, imem_req}, 16'h1);
    check("mid_pre_pc",  pc, 16'h0001);
    rst_n = 1'b0; imem_ack = 1'b1; imem_data = 16'hBEEF;
    tick();
    imem_ack = 1'b0; rst_n = 1'b1; run = 1'b0;
    check("mid_req",   {15'b0, imem_req},    16'h0);
    check("mid_valid", {15'b0, instr_valid}, 16'h0);
    check("mid_pc",    pc,                   16'h0000);
    check("mid_instr", instr,                16'h0000);
    tick();
    check("mid_idle",  {15'b0, imem_req},    16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
